// File: rtl/ebu_pkg.sv
// Shared types and helpers for the bus arbiter.
//   ebu_state_e   : arbiter FSM state (IDLE pass-through / OWNED burst)
//   burst_thresh  : HBURST -> final-beat index of the burst (0, 3, 7, 15)
package ebu_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } ebu_state_e;

  // Only HBURST[2:1] matters: SINGLE/INCR -> 0, 4-beat -> 3, 8-beat -> 7, 16-beat -> 15.
  function automatic logic [3:0] burst_thresh(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b00:   return 4'd0;
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/ebu_rr_pick.sv
// Combinational priority picker.
//   elig  in  NREQ  candidate requestors
//   ptr   in  PW    rotating start index (ignored when ROUNDROBIN=0)
//   win   out NREQ  one-hot winner (zero when elig is zero)
//   idx   out PW    binary index of win
module ebu_rr_pick #(
  parameter int NREQ       = 3,
  parameter int ROUNDROBIN = 1,
  parameter int PW         = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx
);

  logic found;
  int   j;

  // Scan NREQ slots starting at ptr (or 0 for fixed priority), first hit wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (ROUNDROBIN != 0) ? (int'(ptr) + k) % NREQ : k;
      if (!found && elig[j]) begin
        win[j] = 1'b1;
        idx    = PW'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ebu_rr_arb.sv
// AHB external-bus arbiter. Single eligible requestor passes straight through;
// contention grants one owner for a whole burst, the losers save their
// address phase and restore it when they are granted later.
//   HCLK, HRESETn  clock, synchronous active-low reset
//   HBURST, HREADY burst type / ready of the currently muxed transfer
//   Req            per-requestor request
//   Select         one-hot mux select of the bus owner
//   Save           pulse: requestor just lost, capture address phase
//   Restore        level: pending loser drives its saved request
//   Disable        level: requestor squashed from the bus
//   Owner          binary index of Select
module ebu_rr_arb
  import ebu_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ROUNDROBIN = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [2:0]               HBURST,
  input  logic                     HREADY,
  input  logic [NREQ-1:0]          Req,
  output logic [NREQ-1:0]          Select,
  output logic [NREQ-1:0]          Save,
  output logic [NREQ-1:0]          Restore,
  output logic [NREQ-1:0]          Disable,
  output logic [$clog2(NREQ)-1:0]  Owner
);

  localparam int PW = $clog2(NREQ);

  ebu_state_e      state;
  logic [NREQ-1:0] served, pend;
  logic [PW-1:0]   ptr, own_idx;
  logic [3:0]      cnt, thr;
  logic            fbd;

  logic [NREQ-1:0] elig, own_oh, cand, arb_in, win_oh;
  logic [NREQ-1:0] sel_c, save_c, rest_c, dis_c;
  logic [PW-1:0]   win_idx, sel_idx;
  logic            multi, final_beat, beat_en, done, decide;

  assign elig       = Req & ~served;
  assign own_oh     = NREQ'(1) << own_idx;
  // While owned, everyone eligible other than the owner is (or becomes) pending.
  assign cand       = elig & ~own_oh;
  assign arb_in     = (state == ST_OWNED) ? cand : elig;
  assign multi      = |(elig & (elig - NREQ'(1)));
  assign beat_en    = (state == ST_OWNED) && HREADY;
  assign final_beat = (cnt == thr);
  assign done       = beat_en && fbd;
  assign decide     = (state == ST_IDLE) ? multi : (done && |cand);

  ebu_rr_pick #(.NREQ(NREQ), .ROUNDROBIN(ROUNDROBIN), .PW(PW)) u_pick (
    .elig (arb_in),
    .ptr  (ptr),
    .win  (win_oh),
    .idx  (win_idx)
  );

  always_comb begin
    sel_c  = '0;
    save_c = '0;
    rest_c = '0;
    dis_c  = '0;
    if (state == ST_IDLE) begin
      sel_c  = multi ? win_oh : elig;
      save_c = multi ? (elig & ~win_oh) : '0;
      dis_c  = served;
    end else begin
      sel_c  = own_oh;
      // Late arrivals pulse Save once, on the cycle they join the pending set.
      save_c = cand & ~pend;
      rest_c = pend;
      dis_c  = ~own_oh & Req;
    end
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (sel_c[i]) sel_idx = PW'(i);
    // Registers are not yet cleared while reset is asserted: present a clean bus.
    if (!HRESETn) begin
      sel_c   = ((Req & (Req - NREQ'(1))) == '0) ? Req : '0;
      save_c  = '0;
      rest_c  = '0;
      dis_c   = '0;
      sel_idx = '0;
    end
  end

  assign Select  = sel_c;
  assign Save    = save_c;
  assign Restore = rest_c;
  assign Disable = dis_c;
  assign Owner   = sel_idx;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      served  <= '0;
      pend    <= '0;
      ptr     <= '0;
      own_idx <= '0;
      cnt     <= '0;
      thr     <= '0;
      fbd     <= 1'b0;
    end else begin
      served <= served & Req;
      if (state == ST_IDLE) begin
        if (multi) begin
          state   <= ST_OWNED;
          own_idx <= win_idx;
          pend    <= elig & ~win_oh;
          thr     <= burst_thresh(HBURST);
        end
      end else begin
        pend <= cand;
        if (beat_en) begin
          cnt <= cnt + 4'd1;
          fbd <= final_beat;
        end
        if (done) begin
          cnt    <= '0;
          fbd    <= 1'b0;
          served <= (served | own_oh) & Req;
          if (|cand) begin
            own_idx <= win_idx;
            pend    <= cand & ~win_oh;
            thr     <= burst_thresh(HBURST);
          end else begin
            state <= ST_IDLE;
            pend  <= '0;
          end
        end
      end
      if (ROUNDROBIN != 0 && decide)
        ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_ebu_rr_arb.sv
module tb_ebu_rr_arb;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] req, hb;
  logic       hr;

  logic [2:0] r_sel, r_save, r_rest, r_dis;
  logic [1:0] r_own;
  logic [2:0] f_sel, f_save, f_rest, f_dis;
  logic [1:0] f_own;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ebu_rr_arb #(.NREQ(3), .ROUNDROBIN(1)) u_rr (
    .HCLK(clk), .HRESETn(rstn), .HBURST(hb), .HREADY(hr), .Req(req),
    .Select(r_sel), .Save(r_save), .Restore(r_rest), .Disable(r_dis), .Owner(r_own)
  );

  ebu_rr_arb #(.NREQ(3), .ROUNDROBIN(0)) u_fx (
    .HCLK(clk), .HRESETn(rstn), .HBURST(hb), .HREADY(hr), .Req(req),
    .Select(f_sel), .Save(f_save), .Restore(f_rest), .Disable(f_dis), .Owner(f_own)
  );

  typedef struct {
    logic       rstn;
    logic [2:0] req;
    logic [2:0] hb;
    logic       hr;
    logic [2:0] sel;
    logic [2:0] save;
    logic [2:0] rest;
    logic [2:0] dis;
    logic [1:0] own;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", nm, idx, got, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [2:0] q, input logic [2:0] b, input logic h);
    @(posedge clk);
    #1;
    rstn = r; req = q; hb = b; hr = h;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; req = '0; hb = '0; hr = 1'b1;

    //            rstn  req     hb      hr    sel     save    rest    dis     own
    tbl[0]  = '{1'b0, 3'b010, 3'b000, 1'b1, 3'b010, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[1]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[2]  = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 3'b000, 3'b000, 3'b000, 2'd1};
    tbl[3]  = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    // two requestors, single beats: 0 wins, 1 saved, 1 restored after Done
    tbl[4]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 2'd0};
    tbl[5]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b001, 3'b000, 3'b010, 3'b010, 2'd0};
    tbl[6]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b001, 3'b000, 3'b010, 3'b010, 2'd0};
    tbl[7]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b010, 3'b000, 3'b000, 3'b001, 2'd1};
    tbl[8]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b010, 3'b000, 3'b000, 3'b001, 2'd1};
    tbl[9]  = '{1'b1, 3'b011, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011, 2'd0};
    tbl[10] = '{1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011, 2'd0};
    tbl[11] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 2'd0};
    tbl[12] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[13] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    // all three requesting: owners 0,1,2 in turn
    tbl[14] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 3'b110, 3'b000, 3'b000, 2'd0};
    tbl[15] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 3'b000, 3'b110, 3'b110, 2'd0};
    tbl[16] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 3'b000, 3'b110, 3'b110, 2'd0};
    tbl[17] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b010, 3'b000, 3'b100, 3'b101, 2'd1};
    tbl[18] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b010, 3'b000, 3'b100, 3'b101, 2'd1};
    tbl[19] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b100, 3'b000, 3'b000, 3'b011, 2'd2};
    tbl[20] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b100, 3'b000, 3'b000, 3'b011, 2'd2};
    tbl[21] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 2'd0};
    tbl[22] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 2'd0};
    tbl[23] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    // pointer wrapped to 0: with 1 and 2 requesting, 1 wins
    tbl[24] = '{1'b1, 3'b110, 3'b000, 1'b1, 3'b010, 3'b100, 3'b000, 3'b000, 2'd1};
    tbl[25] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};

    for (int i = 0; i < NV; i++) begin
      drv(tbl[i].rstn, tbl[i].req, tbl[i].hb, tbl[i].hr);
      chk("tbl_sel",  i, {5'd0, r_sel},  {5'd0, tbl[i].sel});
      chk("tbl_save", i, {5'd0, r_save}, {5'd0, tbl[i].save});
      chk("tbl_rest", i, {5'd0, r_rest}, {5'd0, tbl[i].rest});
      chk("tbl_dis",  i, {5'd0, r_dis},  {5'd0, tbl[i].dis});
      chk("tbl_own",  i, {6'd0, r_own},  {6'd0, tbl[i].own});
    end

    // Fixed priority, INCR4, Req=111: 0 for grant+4 beats+final, then 1, then 2.
    drv(1'b0, 3'b000, 3'b011, 1'b1);
    for (int c = 0; c < 17; c++) begin
      logic [2:0] es;
      logic [1:0] eo;
      drv(1'b1, 3'b111, 3'b011, 1'b1);
      es = (c < 6) ? 3'b001 : (c < 11) ? 3'b010 : (c < 16) ? 3'b100 : 3'b000;
      eo = (c < 6) ? 2'd0 : (c < 11) ? 2'd1 : (c < 16) ? 2'd2 : 2'd0;
      chk("fx_incr4_sel", c, {5'd0, f_sel}, {5'd0, es});
      chk("fx_incr4_own", c, {6'd0, f_own}, {6'd0, eo});
      if (c == 0) chk("fx_incr4_save", c, {5'd0, f_save}, 8'b110);
    end

    // Fixed priority: late high-priority request queues, no pre-emption.
    drv(1'b0, 3'b000, 3'b011, 1'b1);
    drv(1'b1, 3'b110, 3'b011, 1'b1);
    chk("fx_late_sel", 0, {5'd0, f_sel}, 8'b010);
    chk("fx_late_save", 0, {5'd0, f_save}, 8'b100);
    drv(1'b1, 3'b111, 3'b011, 1'b1);
    chk("fx_late_sel", 1, {5'd0, f_sel}, 8'b010);
    chk("fx_late_save", 1, {5'd0, f_save}, 8'b001);
    chk("fx_late_rest", 1, {5'd0, f_rest}, 8'b100);
    drv(1'b1, 3'b111, 3'b011, 1'b1);
    chk("fx_late_sel", 2, {5'd0, f_sel}, 8'b010);
    chk("fx_late_save", 2, {5'd0, f_save}, 8'b000);
    chk("fx_late_rest", 2, {5'd0, f_rest}, 8'b101);
    chk("fx_late_dis", 2, {5'd0, f_dis}, 8'b101);

    // RR, INCR8 with HREADY low on beats 3: owner holds until 8th ready beat.
    drv(1'b0, 3'b000, 3'b101, 1'b1);
    drv(1'b1, 3'b011, 3'b101, 1'b1);
    chk("incr8_grant_sel", 0, {5'd0, r_sel}, 8'b001);
    chk("incr8_grant_save", 0, {5'd0, r_save}, 8'b010);
    for (int k = 0; k < 11; k++) begin
      drv(1'b1, 3'b011, 3'b101, (k == 2 || k == 3) ? 1'b0 : 1'b1);
      chk("incr8_hold_sel", k, {5'd0, r_sel}, 8'b001);
    end
    drv(1'b1, 3'b011, 3'b101, 1'b1);
    chk("incr8_hand_sel", 0, {5'd0, r_sel}, 8'b010);
    chk("incr8_hand_rest", 0, {5'd0, r_rest}, 8'b000);

    // RR, reset on beat 2 of INCR4: ownership and pointer abandoned.
    drv(1'b0, 3'b000, 3'b011, 1'b1);
    drv(1'b1, 3'b011, 3'b011, 1'b1);
    chk("rst_mid_sel", 0, {5'd0, r_sel}, 8'b001);
    drv(1'b1, 3'b011, 3'b011, 1'b1);
    chk("rst_mid_sel", 1, {5'd0, r_sel}, 8'b001);
    chk("rst_mid_rest", 1, {5'd0, r_rest}, 8'b010);
    drv(1'b0, 3'b011, 3'b011, 1'b1);
    chk("rst_mid_sel", 2, {5'd0, r_sel}, 8'b000);
    chk("rst_mid_rest", 2, {5'd0, r_rest}, 8'b000);
    chk("rst_mid_dis", 2, {5'd0, r_dis}, 8'b000);
    drv(1'b1, 3'b011, 3'b011, 1'b1);
    chk("rst_mid_sel", 3, {5'd0, r_sel}, 8'b001);
    chk("rst_mid_save", 3, {5'd0, r_save}, 8'b010);
    chk("rst_mid_rest", 3, {5'd0, r_rest}, 8'b000);
    chk("rst_mid_dis", 3, {5'd0, r_dis}, 8'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebu_rr_arb.md
EBU_RR_ARB -- requirements
Module: ebu_rr_arb

Interface
REQ-001 Parameter NREQ, default 3, number of bus requestors (2..8); index 0 is highest fixed priority.
REQ-002 Parameter ROUNDROBIN, default 1; 1 selects rotating priority, 0 selects fixed priority.
REQ-003 HCLK  in  1  single clock; all state updates on rising edge.
REQ-004 HRESETn  in  1  reset, synchronous, active-low.
REQ-005 HBURST  in  3  AHB burst type of the currently muxed transfer.
REQ-006 HREADY  in  1  AHB ready; beat/transfer completion.
REQ-007 Req  in  NREQ  per-requestor bus request.
REQ-008 Select  out  NREQ  one-hot (or zero) mux select of the bus owner.
REQ-009 Save  out  NREQ  pulse: requestor lost arbitration; it stores its address-phase signals.
REQ-010 Restore  out  NREQ  level: losing requestor drives its saved request.
REQ-011 Disable  out  NREQ  level: requestor's request is squashed from the bus.
REQ-012 Owner  out  clog2(NREQ)  binary index of current Select bit; 0 when Select is zero.

Function
REQ-013 States IDLE and OWNED; the state type and its encoding live in the shared package.
REQ-014 Eligible = Req & ~Served; Served is an NREQ-bit register.
REQ-015 IDLE with popcount(Eligible) <= 1: Select = Eligible, Save/Restore = 0, state stays IDLE (pass-through, zero-latency).
REQ-016 IDLE with popcount(Eligible) >= 2: winner picked combinationally the same cycle; Select = winner one-hot; Save = Eligible & ~winner; next state OWNED.
REQ-017 Fixed priority: winner is lowest eligible index; round-robin: first eligible index at or above Ptr, wrapping modulo NREQ.
REQ-018 Ptr (clog2(NREQ) bits) updates to (winner+1) mod NREQ on every arbitration decision, only when ROUNDROBIN=1.
REQ-019 Threshold = 0 when HBURST[2:1]=00, else (2 << HBURST[2:1]) - 1 (3, 7, 15); latched when an owner is granted.
REQ-020 Beat counter (4 bits) increments on HREADY while OWNED; FinalBeat = (count == Threshold); FinalBeatD is FinalBeat registered under the same enable.
REQ-021 Done = OWNED & HREADY & FinalBeatD; on Done, counter and FinalBeatD clear and Served[owner] sets.
REQ-022 On Done with remaining Restore-pending requestors eligible: re-arbitrate among them the same cycle, stay OWNED, new owner's Restore clears.
REQ-023 On Done with no pending eligible requestor: next state IDLE, Select follows REQ-015 from the next cycle.
REQ-024 While OWNED: Select = registered owner one-hot; Restore = pending losers; Disable = ~Select & Req.
REQ-025 Served[i] clears when Req[i] is low; Disable[i] = 1 whenever Served[i] = 1 in IDLE.
REQ-026 A new request arriving while OWNED is queued as pending and does not pre-empt the owner.
REQ-027 Save never pulses for a requestor already pending; Save and Select are mutually exclusive per bit.

Reset
REQ-028 HRESETn low at a clock edge: state IDLE, Served, Ptr, pending mask, counter, FinalBeatD, latched Threshold all 0.
REQ-029 During and immediately after reset: Save, Restore, Disable = 0, Owner = 0, Select = Req only if popcount(Req) <= 1.
REQ-030 Reset mid-burst abandons ownership and pending requests with no completion pulse.

Structure
REQ-031 Shared package ebu_pkg holds the state enum and the HBURST-to-threshold function.
REQ-032 One sub-module, ebu_rr_pick: combinational rotating-priority picker (Eligible, Ptr, ROUNDROBIN -> one-hot winner, index).
REQ-033 Implementation uses the codebase flop/counter primitives; 120-400 RTL lines.

Verification
REQ-034 NREQ=3, Req=010, HBURST=000 -> Select=010 same cycle, state IDLE, no Save.
REQ-035 RR, Ptr=0, Req=011 single beats -> Select=001, Save=010; after HREADY Done Select=010, Ptr=2; Req[0] then Disabled until dropped.
REQ-036 Fixed, Req=111, owner 0 HBURST=011 (INCR4) -> Select=001 held exactly 4 HREADY beats plus FinalBeatD, then 010, then 100.
REQ-037 RR, Req held 111 for three Done events -> owner order 0,1,2; Ptr wraps to 0.
REQ-038 HREADY low inserted on beat 3 of INCR8 -> Select holds; handoff only after 8th ready beat.
REQ-039 HRESETn low on beat 2 of INCR4 with Req=011 -> next cycle IDLE, Served=0, Restore=0, arbitration restarts at Ptr=0.
